mem_block_copy: RTL and testbench

Bus-initiator engine that copies a block of 16-bit words from one address range to another over the CPU memory bus (mem_cmd / mem_addr / w_data / r_data). It issues the same MNONE/MREAD/MWRITE commands as the CPU, so the RAM and memory-mapped peripherals respond to it unchanged. This includes the switch input at 0x140 and the LED register at 0x100. Arbitration with the CPU is outside this block: when idle it drives MNONE, and the top-level mux selects the active master.

---
 rtl/mem_block_copy.sv | 94 +++++++++
 tb/tb_mem_block_copy.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_copy.sv
// Bus-initiator block copy engine: reads a word, writes it, advances both pointers.
// Drives the same MNONE/MREAD/MWRITE protocol as the CPU; idle drives MNONE.
module mem_block_copy #(
    parameter int A = 9,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [A-1:0] src_addr,
    input  logic [A-1:0] dst_addr,
    input  logic [A-1:0] len,
    input  logic [W-1:0] r_data,
    output logic [1:0]   mem_cmd,
    output logic [A-1:0] mem_addr,
    output logic [W-1:0] w_data,
    output logic         busy,
    output logic         done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b11;

    localparam logic [A-1:0] ONE = A'(1);

    logic [2:0]   state;
    logic [A-1:0] src_ptr;
    logic [A-1:0] dst_ptr;
    logic [A-1:0] cnt;
    logic [W-1:0] data_buf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            cnt      <= '0;
            data_buf <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        cnt     <= len;
                        state   <= (len == '0) ? S_DONE : S_RD_ADDR;
                    end
                end
                S_RD_ADDR: state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    // RAM has had one full cycle with a stable address; capture now
                    data_buf <= r_data;
                    src_ptr  <= src_ptr + ONE;
                    state    <= S_WR;
                end
                S_WR: begin
                    dst_ptr <= dst_ptr + ONE;
                    cnt     <= cnt - ONE;
                    state   <= (cnt == ONE) ? S_DONE : S_RD_ADDR;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_cmd  = MNONE;
        mem_addr = '0;
        w_data   = '0;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        case (state)
            S_RD_ADDR, S_RD_WAIT: begin
                mem_cmd  = MREAD;
                mem_addr = src_ptr;
            end
            S_WR: begin
                mem_cmd  = MWRITE;
                mem_addr = dst_ptr;
                w_data   = data_buf;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_block_copy.sv
// Bench for mem_block_copy: bus RAM/switch/LED model plus a write scoreboard.
// Expected writes are computed from a shadow memory image when each copy starts.
module tb_mem_block_copy;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  src_addr;
    logic [8:0]  dst_addr;
    logic [8:0]  len;
    logic [15:0] r_data;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] w_data;
    logic        busy;
    logic        done;

    logic [15:0] mem [512];
    logic [15:0] ledr;
    logic [7:0]  sw;

    logic [24:0] exp_q [$];
    logic [10:0] cmd_log [$];
    logic [24:0] e;

    int n_cmp = 0;
    int n_err = 0;

    mem_block_copy #(.A(9), .W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .r_data   (r_data),
        .mem_cmd  (mem_cmd),
        .mem_addr (mem_addr),
        .w_data   (w_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous responders: registered read data, write on the edge ending MWRITE
    always @(posedge clk) begin
        r_data <= (mem_addr == 9'h140) ? {8'h00, sw} : mem[mem_addr];
        if (mem_cmd == 2'b11) begin
            if (mem_addr == 9'h100) ledr <= w_data;
            else                    mem[mem_addr] <= w_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy === 1'b1) cmd_log.push_back({mem_cmd, mem_addr});
        if (mem_cmd === 2'b11) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e[24:16]);
                chk("wr_data", w_data, e[15:0]);
            end
        end
    end

    task automatic push_expect(input logic [8:0] s, input logic [8:0] d, input logic [8:0] l);
        logic [15:0] tmp [512];
        logic [8:0]  sp;
        logic [8:0]  dp;
        logic [15:0] v;
        for (int i = 0; i < 512; i++) tmp[i] = mem[i];
        sp = s;
        dp = d;
        for (int unsigned k = 0; k < l; k++) begin
            v = (sp == 9'h140) ? {8'h00, sw} : tmp[sp];
            if (dp != 9'h100) tmp[dp] = v;
            exp_q.push_back({dp, v});
            sp = sp + 9'd1;
            dp = dp + 9'd1;
        end
    endtask

    task automatic do_copy(input logic [8:0] s, input logic [8:0] d, input logic [8:0] l,
                           input int poke, output int dcyc);
        logic busy_bad;
        push_expect(s, d, l);
        cmd_log.delete();
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = l;
        @(posedge clk);
        @(negedge clk);
        dcyc = -1;
        busy_bad = 1'b0;
        for (int c = 1; c <= 1600; c++) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (done === 1'b1) begin
                dcyc = c;
                break;
            end
            start    = (c == poke);
            src_addr = 9'($urandom);
            dst_addr = 9'($urandom);
            len      = 9'($urandom_range(1, 511));
            @(negedge clk);
        end
        start = 1'b0;
        if (dcyc < 0) chk("done_timeout", 0, 1);
        chk("busy_during", busy_bad, 0);
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
    endtask

    initial begin
        int dc;
        int nz;
        logic [15:0] snap [512];

        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        sw = 8'h5A; ledr = '0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);
        mem[9'h010] = 16'hAAAA; mem[9'h011] = 16'hBBBB; mem[9'h012] = 16'hCCCC;
        for (int i = 9'h020; i < 9'h023; i++) mem[i] = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_cmd", mem_cmd, 2'b00);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", w_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic copy
        do_copy(9'h010, 9'h020, 9'd3, 0, dc);
        chk("basic_done_cyc", dc, 10);
        chk("basic_m0", mem[9'h020], 16'hAAAA);
        chk("basic_m1", mem[9'h021], 16'hBBBB);
        chk("basic_m2", mem[9'h022], 16'hCCCC);

        // Zero length
        for (int i = 0; i < 512; i++) snap[i] = mem[i];
        do_copy(9'h010, 9'h030, 9'd0, 0, dc);
        chk("zero_done_cyc", dc, 1);
        nz = 0;
        foreach (cmd_log[i]) if (cmd_log[i][10:9] != 2'b00) nz++;
        chk("zero_cmd", nz, 0);
        nz = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== snap[i]) nz++;
        chk("zero_mem", nz, 0);

        // Wrap-around
        mem[9'h1FF] = 16'h1234; mem[9'h000] = 16'h5678;
        do_copy(9'h1FF, 9'h0F0, 9'd2, 0, dc);
        chk("wrap_done_cyc", dc, 7);
        chk("wrap_rd0", cmd_log[0], {2'b01, 9'h1FF});
        chk("wrap_wr0", cmd_log[2], {2'b11, 9'h0F0});
        chk("wrap_rd1", cmd_log[3], {2'b01, 9'h000});
        chk("wrap_wr1", cmd_log[5], {2'b11, 9'h0F1});
        chk("wrap_m1", mem[9'h0F1], 16'h5678);

        // Peripherals: switches to LEDs
        do_copy(9'h140, 9'h100, 9'd1, 0, dc);
        chk("per_done_cyc", dc, 4);
        chk("per_ledr", ledr[7:0], 8'h5A);
        chk("per_cmd0", cmd_log[0][10:9], 2'b01);
        chk("per_cmd1", cmd_log[1][10:9], 2'b01);
        chk("per_cmd2", cmd_log[2][10:9], 2'b11);

        // Overlapping ranges: first word propagates forward
        mem[9'h030] = 16'h1111;
        do_copy(9'h030, 9'h031, 9'd3, 0, dc);
        chk("ovl_m3", mem[9'h033], 16'h1111);

        // start while busy is ignored
        for (int i = 0; i < 3; i++) mem[9'h080 + i] = 16'h0;
        do_copy(9'h010, 9'h080, 9'd3, 4, dc);
        chk("poke_done_cyc", dc, 10);
        chk("poke_m2", mem[9'h082], 16'hCCCC);

        // Reset during RD_WAIT of word 2
        for (int i = 0; i < 4; i++) begin
            mem[9'h050 + i] = 16'hC000 + 16'(i);
            mem[9'h060 + i] = 16'hDEAD;
        end
        push_expect(9'h050, 9'h060, 9'd4);
        @(negedge clk);
        start = 1'b1; src_addr = 9'h050; dst_addr = 9'h060; len = 9'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_cmd", mem_cmd, 2'b01);
        chk("mid_addr", mem_addr, 9'h051);
        reset = 1'b1;
        #1;
        chk("arst_cmd", mem_cmd, 2'b00);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("arst_m0", mem[9'h060], 16'hC000);
        chk("arst_m1", mem[9'h061], 16'hDEAD);
        chk("arst_pending", exp_q.size(), 3);
        exp_q.delete();

        do_copy(9'h050, 9'h070, 9'd4, 0, dc);
        chk("after_rst_done_cyc", dc, 13);
        chk("after_rst_m3", mem[9'h073], 16'hC003);

        chk("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
